// File: rtl/alu_auftrag_steuerung_pkg.sv
// Shared definitions for the ALU issue stage: FSM states, error codes,
// function-code constants and the opcode validity decode.
package alu_auftrag_steuerung_pkg;

  // FSM state encoding
  localparam logic [1:0] LEERLAUF = 2'd0;
  localparam logic [1:0] START    = 2'd1;
  localparam logic [1:0] WARTEN   = 2'd2;
  localparam logic [1:0] ERGEBNIS = 2'd3;

  // Fehler encodings presented alongside ErgebnisGueltig
  localparam logic [1:0] FEHLER_OK      = 2'b00;
  localparam logic [1:0] FEHLER_CODE    = 2'b01;
  localparam logic [1:0] FEHLER_TIMEOUT = 2'b10;

  // A few named function codes used around the processor
  localparam logic [5:0] INT_ADDITION   = 6'b000000;
  localparam logic [5:0] FLOAT_ADDITION = 6'b100000;
  localparam logic [5:0] FLOAT_WURZEL   = 6'b100011; // float square root, decoded as an invalid opcode

  // Returns 1 when the ALU implements the given function code.
  function automatic logic code_gueltig(input logic [5:0] code);
    logic ok;
    ok = 1'b0;
    if (code[5] == 1'b0) begin
      if (code[4] == 1'b0) begin
        ok = 1'b1;
      end else begin
        ok = (code[3:0] <= 4'd4) || (code[3:0] == 4'd6) || (code[3:0] == 4'd7);
      end
    end else begin
      case (code[4:0])
        5'b00000, 5'b00001, 5'b00010, 5'b00100,
        5'b01000, 5'b01001, 5'b01010, 5'b01011,
        5'b01110, 5'b01111: ok = 1'b1;
        default:            ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/alu_auftrag_steuerung_if.sv
// Bus bundles around the ALU issue stage: request from decode, the ALU
// start/done link, and the result path to writeback.

interface aas_auftrag_if #(parameter int DATA_W = 32, parameter int TAG_W = 5);
  logic              AuftragGueltig;
  logic              AuftragBereit;
  logic [DATA_W-1:0] AuftragDaten1;
  logic [DATA_W-1:0] AuftragDaten2;
  logic [5:0]        AuftragCode;
  logic [TAG_W-1:0]  AuftragZiel;

  modport master (output AuftragGueltig, AuftragDaten1, AuftragDaten2, AuftragCode, AuftragZiel,
                  input  AuftragBereit);
  modport slave  (input  AuftragGueltig, AuftragDaten1, AuftragDaten2, AuftragCode, AuftragZiel,
                  output AuftragBereit);
endinterface

interface aas_alu_if #(parameter int DATA_W = 32);
  logic [DATA_W-1:0] AluDaten1;
  logic [DATA_W-1:0] AluDaten2;
  logic [5:0]        AluFunktionsCode;
  logic              AluStartSignal;
  logic              AluReset;
  logic              AluFertig;
  logic [DATA_W-1:0] AluErgebnis;

  modport master (output AluDaten1, AluDaten2, AluFunktionsCode, AluStartSignal, AluReset,
                  input  AluFertig, AluErgebnis);
  modport slave  (input  AluDaten1, AluDaten2, AluFunktionsCode, AluStartSignal, AluReset,
                  output AluFertig, AluErgebnis);
endinterface

interface aas_ergebnis_if #(parameter int DATA_W = 32, parameter int TAG_W = 5);
  logic              ErgebnisGueltig;
  logic              ErgebnisBereit;
  logic [DATA_W-1:0] ErgebnisDaten;
  logic [TAG_W-1:0]  ErgebnisZiel;
  logic [1:0]        Fehler;

  modport master (output ErgebnisGueltig, ErgebnisDaten, ErgebnisZiel, Fehler,
                  input  ErgebnisBereit);
  modport slave  (input  ErgebnisGueltig, ErgebnisDaten, ErgebnisZiel, Fehler,
                  output ErgebnisBereit);
endinterface

// File: rtl/alu_auftrag_steuerung_code_pruefer.sv
// Combinational opcode check: flags function codes the ALU implements.
module alu_auftrag_steuerung_code_pruefer
  import alu_auftrag_steuerung_pkg::*;
(
  input  logic [5:0] code,
  output logic       gueltig
);

  // Decode the incoming code against the implemented opcode map
  always_comb begin
    gueltig = code_gueltig(code);
  end

endmodule

// File: rtl/alu_auftrag_steuerung.sv
// ALU issue stage: accepts one operation from decode, starts the ALU,
// waits for done (guarded by a watchdog) and hands the result to writeback.
module alu_auftrag_steuerung
  import alu_auftrag_steuerung_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic           Clock,
  input  logic           Reset,
  aas_auftrag_if.slave   auftrag,
  aas_alu_if.master      alu,
  aas_ergebnis_if.master ergebnis,
  output logic           Beschaeftigt
);

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_EINS = WD_W'(1);

  logic [1:0]        state_r;
  logic [DATA_W-1:0] daten1_r;
  logic [DATA_W-1:0] daten2_r;
  logic [5:0]        code_r;
  logic [TAG_W-1:0]  ziel_r;
  logic [DATA_W-1:0] erg_daten_r;
  logic [1:0]        fehler_r;
  logic [WD_W-1:0]   wd_r;
  logic              abbruch_r;

  logic code_ok_s;
  logic bereit_s;
  logic annahme_s;

  alu_auftrag_steuerung_code_pruefer u_code_pruefer (
    .code    (auftrag.AuftragCode),
    .gueltig (code_ok_s)
  );

  // Request acceptance: idle, or ERGEBNIS while writeback takes the result
  always_comb begin
    bereit_s = 1'b0;
    if (Reset) begin
      bereit_s = 1'b0;
    end else if (state_r == LEERLAUF) begin
      bereit_s = 1'b1;
    end else if (state_r == ERGEBNIS) begin
      bereit_s = ergebnis.ErgebnisBereit;
    end else begin
      bereit_s = 1'b0;
    end
    annahme_s = bereit_s & auftrag.AuftragGueltig;
  end

  // FSM, operand/result registers and the saturating watchdog
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r     <= LEERLAUF;
      daten1_r    <= {DATA_W{1'b0}};
      daten2_r    <= {DATA_W{1'b0}};
      code_r      <= 6'b000000;
      ziel_r      <= {TAG_W{1'b0}};
      erg_daten_r <= {DATA_W{1'b0}};
      fehler_r    <= FEHLER_OK;
      wd_r        <= {WD_W{1'b0}};
      abbruch_r   <= 1'b0;
    end else begin
      abbruch_r <= 1'b0;
      case (state_r)
        LEERLAUF, ERGEBNIS: begin
          if (annahme_s) begin
            daten1_r <= auftrag.AuftragDaten1;
            daten2_r <= auftrag.AuftragDaten2;
            code_r   <= auftrag.AuftragCode;
            ziel_r   <= auftrag.AuftragZiel;
            if (code_ok_s) begin
              state_r <= START;
            end else begin
              // Unimplemented opcode: report directly, ALU is never started
              state_r     <= ERGEBNIS;
              erg_daten_r <= {DATA_W{1'b0}};
              fehler_r    <= FEHLER_CODE;
            end
          end else if ((state_r == ERGEBNIS) && ergebnis.ErgebnisBereit) begin
            state_r <= LEERLAUF;
          end else begin
            state_r <= state_r;
          end
        end
        START: begin
          // Done is ignored here: the ALU countdown is not loaded yet
          state_r <= WARTEN;
          wd_r    <= {WD_W{1'b0}};
        end
        WARTEN: begin
          if (wd_r != WD_MAX) begin
            wd_r <= wd_r + WD_EINS;
          end else begin
            wd_r <= wd_r;
          end
          if (alu.AluFertig) begin
            state_r     <= ERGEBNIS;
            erg_daten_r <= alu.AluErgebnis;
            fehler_r    <= FEHLER_OK;
          end else if (wd_r == WD_MAX) begin
            // Hung operation: reset the ALU for one cycle and report timeout
            state_r     <= ERGEBNIS;
            erg_daten_r <= {DATA_W{1'b0}};
            fehler_r    <= FEHLER_TIMEOUT;
            abbruch_r   <= 1'b1;
          end else begin
            state_r <= WARTEN;
          end
        end
        default: begin
          state_r <= LEERLAUF;
        end
      endcase
    end
  end

  assign auftrag.AuftragBereit = bereit_s;

  assign alu.AluDaten1        = daten1_r;
  assign alu.AluDaten2        = daten2_r;
  assign alu.AluFunktionsCode = code_r;
  assign alu.AluStartSignal   = (state_r == START) && !Reset;
  assign alu.AluReset         = Reset | abbruch_r;

  assign ergebnis.ErgebnisGueltig = (state_r == ERGEBNIS) && !Reset;
  assign ergebnis.ErgebnisDaten   = erg_daten_r;
  assign ergebnis.ErgebnisZiel    = ziel_r;
  assign ergebnis.Fehler          = fehler_r;

  assign Beschaeftigt = (state_r != LEERLAUF) && !Reset;

endmodule

// File: tb/tb_alu_auftrag_steuerung.sv
// Scoreboard bench for alu_auftrag_steuerung with a small start/done ALU model.
module tb_alu_auftrag_steuerung;

  localparam int DATA_W  = 32;
  localparam int TAG_W   = 5;
  localparam int TIMEOUT = 8;

  typedef struct { logic [31:0] data; logic [4:0] ziel; logic [1:0] fehler; int cyc; } exp_t;
  typedef struct { logic [31:0] d1; logic [31:0] d2; logic [5:0] code; } op_t;
  typedef struct { int lat; logic [31:0] res; logic hang; } alu_op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  exp_t    sb_q[$];
  op_t     op_q[$];
  alu_op_t alu_q[$];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_starts = 0;
  int exp_starts = 0;
  int n_abort = 0;
  int alu_rd = 0;
  int alu_cnt = 0;
  logic alu_hang = 1'b0;
  logic [31:0] alu_res = 32'h0;

  always #5 clk = ~clk;

  aas_auftrag_if  #(.DATA_W(DATA_W), .TAG_W(TAG_W)) auf ();
  aas_alu_if      #(.DATA_W(DATA_W))                alu ();
  aas_ergebnis_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) erg ();

  alu_auftrag_steuerung #(.DATA_W(DATA_W), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .Clock        (clk),
    .Reset        (rst),
    .auftrag      (auf),
    .alu          (alu),
    .ergebnis     (erg),
    .Beschaeftigt (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // ALU model: done whenever its countdown is zero (also before loading)
  always @(posedge clk) begin
    if (alu.AluReset) begin
      alu_cnt  <= 0;
      alu_hang <= 1'b0;
    end else if (alu.AluStartSignal && (alu_rd < alu_q.size())) begin
      alu_cnt  <= alu_q[alu_rd].lat;
      alu_res  <= alu_q[alu_rd].res;
      alu_hang <= alu_q[alu_rd].hang;
      alu_rd   <= alu_rd + 1;
    end else if (alu_cnt != 0) begin
      alu_cnt <= alu_cnt - 1;
    end
  end
  assign alu.AluFertig   = !alu_hang && (alu_cnt == 0);
  assign alu.AluErgebnis = alu_res;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // Present one request and wait (bounded) for the handshake; expected values are pushed on acceptance
  task automatic issue(input logic [5:0] code, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [4:0] ziel, input int lat, input logic hang,
                       input logic [31:0] exp_d, input logic [1:0] exp_f);
    exp_t e;
    op_t o;
    alu_op_t a;
    int waited;
    logic done;
    auf.AuftragGueltig = 1'b1;
    auf.AuftragDaten1  = d1;
    auf.AuftragDaten2  = d2;
    auf.AuftragCode    = code;
    auf.AuftragZiel    = ziel;
    waited = 0;
    done = 1'b0;
    while (!done && waited < 200) begin
      @(negedge clk);
      if (auf.AuftragBereit) begin
        done = 1'b1;
        e.data = exp_d;
        e.ziel = ziel;
        e.fehler = exp_f;
        if (exp_f == 2'b01) e.cyc = cyc + 1;
        else if (hang) e.cyc = cyc + TIMEOUT + 3;
        else e.cyc = cyc + lat + 3;
        sb_q.push_back(e);
        if (exp_f != 2'b01) begin
          o.d1 = d1; o.d2 = d2; o.code = code;
          op_q.push_back(o);
          a.lat = lat; a.res = exp_d; a.hang = hang;
          if (hang) a.res = 32'hDEAD_BEEF;
          alu_q.push_back(a);
          exp_starts++;
        end
      end
      @(posedge clk); #1;
      waited++;
    end
    auf.AuftragGueltig = 1'b0;
    if (!done) fail_now("request_not_accepted");
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      fail_now("result_timeout");
      sb_q.delete();
    end
  endtask

  // Monitor: start/hold/abort checks and scoreboard comparison on each result
  initial begin : monitor
    exp_t e;
    op_t o;
    logic pending, start_prev, abort_prev, hold_act;
    logic [31:0] h_d1, h_d2, h_daten;
    logic [5:0] h_code;
    logic [4:0] h_ziel;
    logic [1:0] h_f;
    pending = 1'b0; start_prev = 1'b0; abort_prev = 1'b0; hold_act = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pending = 1'b0; start_prev = 1'b0; abort_prev = 1'b0; hold_act = 1'b0;
      end else begin
        if (alu.AluStartSignal) begin
          n_starts++;
          check("start_one_cycle", 32'(start_prev), 32'd0);
          if (op_q.size() == 0) begin
            fail_now("start_without_request");
          end else begin
            o = op_q.pop_front();
            check("alu_daten1", alu.AluDaten1, o.d1);
            check("alu_daten2", alu.AluDaten2, o.d2);
            check("alu_code", 32'(alu.AluFunktionsCode), 32'(o.code));
            h_d1 = o.d1; h_d2 = o.d2; h_code = o.code;
            hold_act = 1'b1;
          end
        end else if (hold_act) begin
          check("alu_daten1_held", alu.AluDaten1, h_d1);
          check("alu_daten2_held", alu.AluDaten2, h_d2);
          check("alu_code_held", 32'(alu.AluFunktionsCode), 32'(h_code));
        end
        start_prev = alu.AluStartSignal;

        if (alu.AluReset) begin
          n_abort++;
          check("abort_one_cycle", 32'(abort_prev), 32'd0);
        end
        abort_prev = alu.AluReset;

        if (erg.ErgebnisGueltig) begin
          if (!pending) begin
            if (sb_q.size() == 0) begin
              fail_now("spurious_result");
            end else begin
              check("result_latency", 32'(cyc), 32'(sb_q[0].cyc));
              check("abort_at_timeout", 32'(alu.AluReset), (sb_q[0].fehler == 2'b10) ? 32'd1 : 32'd0);
            end
          end else begin
            check("daten_stable", erg.ErgebnisDaten, h_daten);
            check("ziel_stable", 32'(erg.ErgebnisZiel), 32'(h_ziel));
            check("fehler_stable", 32'(erg.Fehler), 32'(h_f));
          end
          if (!erg.ErgebnisBereit) check("auftrag_bereit_stall", 32'(auf.AuftragBereit), 32'd0);
          h_daten = erg.ErgebnisDaten; h_ziel = erg.ErgebnisZiel; h_f = erg.Fehler;
          if (erg.ErgebnisBereit) begin
            if (sb_q.size() != 0) begin
              e = sb_q.pop_front();
              check("ergebnis_daten", erg.ErgebnisDaten, e.data);
              check("ergebnis_ziel", 32'(erg.ErgebnisZiel), 32'(e.ziel));
              check("fehler", 32'(erg.Fehler), 32'(e.fehler));
            end
            pending = 1'b0;
            hold_act = 1'b0;
          end else begin
            pending = 1'b1;
          end
        end else begin
          if (pending) fail_now("result_dropped");
          pending = 1'b0;
        end
      end
    end
  end

  initial begin : safety_net
    #200000;
    $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "bench timeout");
  end

  logic [5:0]  tbl_code [7];
  logic [1:0]  tbl_f    [7];

  initial begin : stimulus
    auf.AuftragGueltig = 1'b0;
    auf.AuftragDaten1 = 32'h0;
    auf.AuftragDaten2 = 32'h0;
    auf.AuftragCode = 6'b000000;
    auf.AuftragZiel = 5'd0;
    erg.ErgebnisBereit = 1'b1;
    tbl_code = '{6'b010100, 6'b010101, 6'b010111, 6'b100100, 6'b100101, 6'b101100, 6'b110000};
    tbl_f    = '{2'b00,     2'b01,     2'b00,     2'b00,     2'b01,     2'b01,     2'b01};

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("alu_reset_in_reset", 32'(alu.AluReset), 32'd1);
    check("bereit_in_reset", 32'(auf.AuftragBereit), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_bereit", 32'(auf.AuftragBereit), 32'd1);
    check("rst_gueltig", 32'(erg.ErgebnisGueltig), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(alu.AluStartSignal), 32'd0);
    check("rst_alu_reset", 32'(alu.AluReset), 32'd0);
    check("rst_daten", erg.ErgebnisDaten, 32'd0);
    check("rst_fehler", 32'(erg.Fehler), 32'd0);
    check("rst_alu_daten1", alu.AluDaten1, 32'd0);
    @(posedge clk); #1;

    // 1) IntAddition 5+7, single-cycle
    issue(6'b000000, 32'd5, 32'd7, 5'd3, 0, 1'b0, 32'd12, 2'b00);
    wait_done(50);
    // 2) FloatAddition 1.0+2.0, load count 7
    issue(6'b100000, 32'h3F80_0000, 32'h4000_0000, 5'd7, 7, 1'b0, 32'h4040_0000, 2'b00);
    wait_done(50);
    // 3) IntDivision -7/2 (bench divider uses 6 load cycles), then float sqrt rejected
    issue(6'b001100, 32'hFFFF_FFF9, 32'd2, 5'd5, 6, 1'b0, 32'hFFFF_FFFD, 2'b00);
    wait_done(50);
    issue(6'b100011, 32'd9, 32'd0, 5'd6, 0, 1'b0, 32'd0, 2'b01);
    wait_done(50);
    // Opcode map boundaries
    for (int i = 0; i < 7; i++) begin
      issue(tbl_code[i], 32'(i), 32'd1, 5'(i + 10), 2, 1'b0,
            (tbl_f[i] == 2'b01) ? 32'd0 : 32'h1000 + 32'(i), tbl_f[i]);
      wait_done(50);
    end
    issue(6'b101111, 32'hAAAA_5555, 32'h1, 5'd17, 2, 1'b0, 32'h0000_00AB, 2'b00);
    wait_done(50);

    // 4) Writeback stall with a queued request; back-to-back on release
    erg.ErgebnisBereit = 1'b0;
    issue(6'b000000, 32'd1, 32'd2, 5'd1, 0, 1'b0, 32'd3, 2'b00);
    fork
      begin
        repeat (12) @(posedge clk);
        #1;
        erg.ErgebnisBereit = 1'b1;
      end
      issue(6'b000001, 32'd10, 32'd4, 5'd2, 0, 1'b0, 32'd6, 2'b00);
    join
    wait_done(50);

    // 5) Hung ALU -> watchdog abort
    issue(6'b100001, 32'h1234_5678, 32'h1, 5'd9, 0, 1'b1, 32'd0, 2'b10);
    wait_done(50);

    // 6) Reset while waiting on the ALU
    issue(6'b001100, 32'd100, 32'd7, 5'd4, 6, 1'b0, 32'd14, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("wrst_alu_reset", 32'(alu.AluReset), 32'd1);
    check("wrst_gueltig", 32'(erg.ErgebnisGueltig), 32'd0);
    check("wrst_start", 32'(alu.AluStartSignal), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("wrst_after_gueltig", 32'(erg.ErgebnisGueltig), 32'd0);
    check("wrst_after_busy", 32'(busy), 32'd0);
    check("wrst_after_bereit", 32'(auf.AuftragBereit), 32'd1);
    repeat (15) @(posedge clk);
    #1;
    issue(6'b000000, 32'd100, 32'd23, 5'd31, 0, 1'b0, 32'd123, 2'b00);
    wait_done(50);
    repeat (3) @(posedge clk);
    #1;

    check("start_count", 32'(n_starts), 32'(exp_starts));
    check("abort_count", 32'(n_abort), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
